// File: rtl/shift_sio_frame_if.sv
// Bundle of the serial/parallel frame signals between a link-side controller
// (master) and the shift_sio_frame shifter (slave). Bit index 0 of pin/dout is
// the MSB of the word.
interface shift_sio_frame_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic               cs;
   logic               le;
   logic               ld;
   logic               din;
   logic [0:WIDTH-1]   pin;
   logic               sout;
   logic [0:WIDTH-1]   dout;
   logic [CW-1:0]      bit_cnt;
   logic               full;
   logic               done;
   logic               ovf;

   modport master (
      output cs, le, ld, din, pin,
      input  sout, dout, bit_cnt, full, done, ovf
   );

   modport slave (
      input  cs, le, ld, din, pin,
      output sout, dout, bit_cnt, full, done, ovf
   );
endinterface

// File: rtl/shift_sio_frame.sv
// Framed serial shift register: one shifter serves both transmit (parallel
// load then shift out) and receive (shift in then latch). A bit counter tracks
// the frame and, when AUTO_LATCH is set, copies each completed word into the
// held parallel output without needing an explicit latch request.
module shift_sio_frame #(
   parameter int WIDTH      = 8,
   parameter bit LSB_FIRST  = 1'b0,
   parameter bit AUTO_LATCH = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   shift_sio_frame_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   logic [0:WIDTH-1] shifter;
   logic [0:WIDTH-1] shifted;
   logic [0:WIDTH-1] dout_q;
   logic [CW-1:0]    cnt;
   logic             done_q;
   logic             ovf_q;

   // Word the shifter would hold after one shift; also the word captured by an
   // auto-latch, so the latched value already includes the final din bit.
   always_comb begin
      shifted = shifter;
      if (LSB_FIRST) begin
         shifted = {bus.din, shifter[0:WIDTH-2]};
      end else begin
         shifted = {shifter[1:WIDTH-1], bus.din};
      end
   end

   // Frame state: latch beats load beats shift, and a deselected block holds
   // everything except the done pulse, which always falls after one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         shifter <= '0;
         dout_q  <= '0;
         cnt     <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.cs) begin
            if (bus.le) begin
               dout_q <= shifter;
               cnt    <= '0;
               ovf_q  <= 1'b0;
            end else if (bus.ld) begin
               shifter <= bus.pin;
               cnt     <= '0;
            end else begin
               shifter <= shifted;
               if (AUTO_LATCH) begin
                  if (cnt == LAST_CNT) begin
                     dout_q <= shifted;
                     cnt    <= '0;
                     done_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  if (cnt == FULL_CNT) begin
                     ovf_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
         end
      end
   end

   assign bus.sout    = LSB_FIRST ? shifter[WIDTH-1] : shifter[0];
   assign bus.dout    = dout_q;
   assign bus.bit_cnt = cnt;
   assign bus.full    = (cnt == FULL_CNT);
   assign bus.done    = done_q;
   assign bus.ovf     = ovf_q;
endmodule
